// File: rtl/jala_pkg.sv
// Shared definitions for the jala core observers: control-FSM encodings and the trace entry.
package jala_pkg;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 5'd0,
    ST_DECODE = 5'd1,
    ST_EXEC   = 5'd2,
    ST_MEM    = 5'd3,
    ST_WB     = 5'd4
  } ctrl_state_e;

  typedef struct packed {
    logic [STATE_W-1:0] cur;
    logic [STATE_W-1:0] nxt;
  } trace_entry_t;

  localparam int TRACE_W = $bits(trace_entry_t);

endpackage

// File: rtl/jala_trace_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only alongside a pop.
// Head data comes straight from storage flops and reads as 0 while empty.
module jala_trace_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o && !flush_i;
  // When full, the write lands in the slot being popped this same edge.
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/jala_state_monitor.sv
// Passive observer of the core control FSM: cycle/instruction counters, hang detection
// and a drop-accounted trace of state transitions drained over valid/ready.
module jala_state_monitor
  import jala_pkg::*;
#(
  parameter logic [STATE_W-1:0] FETCH_STATE = ST_FETCH,
  parameter int                 HANG_LIMIT  = 1024,
  parameter int                 TRACE_DEPTH = 8,
  parameter int                 CNT_W       = 32
) (
  input  logic                 CLK,
  input  logic                 Rst_n,
  input  logic                 CtrlRst,
  input  logic [STATE_W-1:0]   CurrentState,
  input  logic [STATE_W-1:0]   NextState,
  input  logic                 Enable,
  input  logic                 ClearStats,
  output logic                 TraceValid,
  input  logic                 TraceReady,
  output logic [2*STATE_W-1:0] TraceData,
  output logic                 TraceOverflow,
  output logic [CNT_W-1:0]     DropCount,
  output logic [CNT_W-1:0]     CycleCount,
  output logic [CNT_W-1:0]     InstrCount,
  output logic                 Hang,
  output logic [STATE_W-1:0]   HangState
);

  localparam int              SLC_W   = $clog2(HANG_LIMIT);
  localparam logic [SLC_W-1:0] SLC_MAX = SLC_W'(HANG_LIMIT - 1);

  logic [CNT_W-1:0]   cyc_q, cyc_d, instr_q, instr_d, drop_q, drop_d;
  logic [SLC_W-1:0]   slc_q, slc_d;
  logic               ovf_q, ovf_d, hang_q, hang_d;
  logic [STATE_W-1:0] hang_st_q, hang_st_d;

  logic         active, self_loop, trans, pop, drop;
  logic         fifo_full, fifo_empty;
  trace_entry_t push_entry;

  assign active     = Enable && !CtrlRst;
  assign self_loop  = active && (NextState == CurrentState);
  assign trans      = active && (NextState != CurrentState);
  assign pop        = TraceValid && TraceReady;
  assign drop       = trans && fifo_full && !pop;
  assign push_entry = '{cur: CurrentState, nxt: NextState};

  jala_trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (Rst_n),
    .push_i  (trans),
    .pop_i   (TraceReady),
    .flush_i (ClearStats),
    .data_i  (push_entry),
    .data_o  (TraceData),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign TraceValid = !fifo_empty;

  always_comb begin
    cyc_d     = cyc_q;
    instr_d   = instr_q;
    drop_d    = drop_q;
    ovf_d     = ovf_q;
    slc_d     = '0;
    hang_d    = hang_q;
    hang_st_d = hang_st_q;
    if (ClearStats) begin
      cyc_d     = '0;
      instr_d   = '0;
      drop_d    = '0;
      ovf_d     = 1'b0;
      hang_d    = 1'b0;
      hang_st_d = '0;
    end else begin
      if (active && !(&cyc_q)) cyc_d = cyc_q + CNT_W'(1);
      if (trans && NextState == FETCH_STATE && !(&instr_q)) instr_d = instr_q + CNT_W'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (!(&drop_q)) drop_d = drop_q + CNT_W'(1);
      end
      // slc stays 0 on transitions and inactive cycles; it saturates at SLC_MAX.
      if (self_loop) begin
        slc_d = (slc_q == SLC_MAX) ? slc_q : slc_q + SLC_W'(1);
        if (slc_q == SLC_MAX && !hang_q) begin
          hang_d    = 1'b1;
          hang_st_d = CurrentState;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      cyc_q     <= '0;
      instr_q   <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
      slc_q     <= '0;
      hang_q    <= 1'b0;
      hang_st_q <= '0;
    end else begin
      cyc_q     <= cyc_d;
      instr_q   <= instr_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
      slc_q     <= slc_d;
      hang_q    <= hang_d;
      hang_st_q <= hang_st_d;
    end
  end

  assign CycleCount    = cyc_q;
  assign InstrCount    = instr_q;
  assign DropCount     = drop_q;
  assign TraceOverflow = ovf_q;
  assign Hang          = hang_q;
  assign HangState     = hang_st_q;

endmodule

// File: tb/tb_jala_state_monitor.sv
// Randomised and directed bench for jala_state_monitor with a queue-based trace scoreboard.
module tb_jala_state_monitor;

  localparam int DEPTH = 8;
  localparam int HL    = 16;
  localparam longint CMAX = 64'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        Rst_n = 1'b0;
  logic        CtrlRst = 1'b0;
  logic [4:0]  CurrentState = '0;
  logic [4:0]  NextState = '0;
  logic        Enable = 1'b0;
  logic        ClearStats = 1'b0;
  logic        TraceValid;
  logic        TraceReady = 1'b0;
  logic [9:0]  TraceData;
  logic        TraceOverflow;
  logic [31:0] DropCount, CycleCount, InstrCount;
  logic        Hang;
  logic [4:0]  HangState;

  jala_state_monitor #(
    .FETCH_STATE (5'd0),
    .HANG_LIMIT  (HL),
    .TRACE_DEPTH (DEPTH),
    .CNT_W       (32)
  ) dut (
    .CLK           (CLK),
    .Rst_n         (Rst_n),
    .CtrlRst       (CtrlRst),
    .CurrentState  (CurrentState),
    .NextState     (NextState),
    .Enable        (Enable),
    .ClearStats    (ClearStats),
    .TraceValid    (TraceValid),
    .TraceReady    (TraceReady),
    .TraceData     (TraceData),
    .TraceOverflow (TraceOverflow),
    .DropCount     (DropCount),
    .CycleCount    (CycleCount),
    .InstrCount    (InstrCount),
    .Hang          (Hang),
    .HangState     (HangState)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: FIFO contents in the scoreboard queue, plus plain counters.
  logic [9:0] exp_q[$];
  longint m_cyc, m_instr, m_drop;
  bit     m_ovf, m_hang;
  int     m_hs, m_run;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cyc = 0; m_instr = 0; m_drop = 0;
    m_ovf = 0; m_hang = 0; m_hs = 0; m_run = 0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_cycles"}, CycleCount, m_cyc);
    chk({tag, "_instr"}, InstrCount, m_instr);
    chk({tag, "_drops"}, DropCount, m_drop);
    chk({tag, "_ovf"}, TraceOverflow, m_ovf);
    chk({tag, "_hang"}, Hang, m_hang);
    chk({tag, "_hangstate"}, HangState, m_hs);
  endtask

  // Called at posedge+1; applies one cycle and updates the model after the edge.
  task automatic step(input bit en, input bit crst, input bit clr, input bit rdy,
                      input int cur, input int nxt);
    bit act, tr, pop_m, acc, drp;
    int occ;
    Enable = en; CtrlRst = crst; ClearStats = clr; TraceReady = rdy;
    CurrentState = cur[4:0]; NextState = nxt[4:0];
    occ   = exp_q.size();
    act   = en && !crst;
    tr    = act && (cur != nxt);
    pop_m = rdy && (occ > 0);
    acc   = tr && (occ < DEPTH || pop_m);
    drp   = tr && !acc;
    @(posedge CLK);
    #1;
    if (clr) begin
      model_clear();
    end else begin
      if (act) m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : m_cyc;
      if (tr && nxt == 0 && m_instr < CMAX) m_instr++;
      if (acc) exp_q.push_back({cur[4:0], nxt[4:0]});
      if (drp) begin
        m_ovf = 1;
        if (m_drop < CMAX) m_drop++;
      end
      if (act && cur == nxt) begin
        m_run++;
        if (m_run >= HL && !m_hang) begin
          m_hang = 1;
          m_hs = cur;
        end
      end else begin
        m_run = 0;
      end
    end
    chk_status("step");
  endtask

  // Trace monitor: every handshake must deliver the oldest outstanding entry.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge CLK);
      if (Rst_n) begin
        chk("trace_valid", TraceValid, exp_q.size() > 0);
        if (TraceValid && TraceReady && !ClearStats) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL trace_unexpected: got entry %h, expected none", TraceData);
          end else begin
            e = exp_q.pop_front();
            chk("trace_data", TraceData, e);
          end
        end
      end
    end
  end

  initial begin
    int rc, nx;
    bit en, cr, cl;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    Rst_n = 1'b1;
    #1;
    chk("rst_valid", TraceValid, 0);
    chk("rst_data", TraceData, 0);
    chk_status("rst");

    @(posedge CLK); #1;
    // Simple instruction loop with an always-ready host.
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 1, 2);
    step(1, 0, 0, 1, 2, 3);
    step(1, 0, 0, 1, 3, 0);
    chk("t1_cycles", CycleCount, 4);
    chk("t1_instr", InstrCount, 1);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    chk("t1_drained", exp_q.size(), 0);

    // Stalled host: overflow by two.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 4 + i, 5 + i);
    chk("t2_valid", TraceValid, 1);
    chk("t2_drops", DropCount, 2);
    chk("t2_ovf", TraceOverflow, 1);
    repeat (9) step(0, 0, 0, 1, 0, 0);
    chk("t2_drained", TraceValid, 0);

    // Full FIFO with a simultaneous pop and push: no drop, entry lands last.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 16 + i, 17 + i);
    step(1, 0, 0, 1, 30, 31);
    chk("t3_drops", DropCount, 2);
    chk("t3_occ_full", exp_q.size(), DEPTH);
    repeat (9) step(0, 0, 0, 1, 0, 0);
    chk("t3_drained", TraceValid, 0);

    // Hang after exactly HL self-loop cycles; a late transition prevents it.
    step(0, 0, 1, 0, 0, 0);
    repeat (HL - 1) step(1, 0, 0, 1, 7, 7);
    chk("t4_hang_early", Hang, 0);
    step(1, 0, 0, 1, 7, 7);
    chk("t4_hang", Hang, 1);
    chk("t4_hangstate", HangState, 7);
    step(1, 0, 0, 1, 9, 9);
    chk("t4_hangstate_sticky", HangState, 7);
    step(0, 0, 1, 1, 0, 0);
    repeat (HL - 2) step(1, 0, 0, 1, 7, 7);
    step(1, 0, 0, 1, 7, 8);
    step(1, 0, 0, 1, 8, 8);
    chk("t4_nohang", Hang, 0);

    // CtrlRst mid self-loop restarts the hang count and freezes the counters.
    step(0, 0, 1, 1, 0, 0);
    repeat (12) step(1, 0, 0, 1, 7, 7);
    repeat (3) step(1, 1, 0, 1, 7, 7);
    chk("t5_frozen_cycles", CycleCount, 12);
    repeat (HL - 1) step(1, 0, 0, 1, 7, 7);
    chk("t5_hang_early", Hang, 0);
    step(1, 0, 0, 1, 7, 7);
    chk("t5_hang", Hang, 1);

    // Random traffic.
    rc = 0;
    for (int i = 0; i < 600; i++) begin
      nx = ($urandom_range(99) < 85) ? rc : int'($urandom_range(5));
      en = $urandom_range(99) < 92;
      cr = $urandom_range(99) < 5;
      cl = $urandom_range(199) == 0;
      step(en, cr, cl, $urandom_range(1), rc, nx);
      rc = nx;
    end
    repeat (DEPTH + 1) step(0, 0, 0, 1, 0, 0);

    // Async reset with entries in flight.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, i + 1, i + 2);
    #2;
    Rst_n = 1'b0;
    #1;
    model_clear();
    chk("t6_arst_valid", TraceValid, 0);
    chk("t6_arst_data", TraceData, 0);
    chk_status("t6_arst");
    @(posedge CLK); #1;
    Enable = 1'b0;
    Rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    // Sync clear with a same-cycle push and pop.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, i + 1, i + 2);
    step(1, 0, 1, 1, 10, 11);
    chk("t6_clr_valid", TraceValid, 0);
    chk("t6_clr_cycles", CycleCount, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t6_clr_still_empty", TraceValid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
